// File: rtl/lisp_defs_pkg.sv
// Shared definitions for the Lisp heap memory subsystem: arbiter states,
// requester indices and the default memory watchdog limit.
package lisp_defs;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam int REQ_EVAL   = 0;
  localparam int REQ_LOADER = 1;
  localparam int REQ_GC     = 2;

  localparam int MEM_TIMEOUT = 64;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first valid requester strictly after
// last_i, wrapping modulo NUM_REQ (works for non-power-of-2 counts).
module rr_select #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_valid_o
);

  always_comb begin
    int  idx;
    logic found;
    idx         = 0;
    found       = 1'b0;
    winner_o    = '0;
    any_valid_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // last_i < NUM_REQ, so one conditional subtract is a full modulo.
      idx = int'(last_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && valid_i[idx[IDX_W-1:0]]) begin
        found    = 1'b1;
        winner_o = idx[IDX_W-1:0];
      end
    end
    any_valid_o = found;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port Lisp heap among requesters,
// one outstanding access at a time, with a sticky watchdog on mem_ready.
module mem_arbiter
  import lisp_defs::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      timeout_err,
  output logic [1:0]                timeout_id,
  output arb_state_t                dbg_state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Handshake: a requester holds req_valid until it sees req_grant (a
  // same-cycle, one-cycle pulse); completion is a one-cycle resp_valid pulse
  // to that requester only, and the memory sees a one-cycle mem_req.

  arb_state_t           state_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     last_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [DATA_W-1:0]    resp_data_q;
  logic                 timeout_err_q;
  logic [1:0]           timeout_id_q;

  logic [IDX_W-1:0]     winner;
  logic                 any_valid;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .valid_i     (req_valid),
    .last_i      (last_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  always_comb begin
    req_grant = '0;
    if (state_q == ARB_IDLE && any_valid) begin
      req_grant = NUM_REQ'(1) << winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      owner_q       <= '0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (any_valid) begin
            owner_q   <= winner;
            last_q    <= winner;
            we_q      <= req_we[winner];
            addr_q    <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            wdata_q   <= req_wdata[int'(winner)*DATA_W +: DATA_W];
            mem_req_q <= 1'b1;
            mem_we_q  <= req_we[winner];
            state_q   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // A late mem_ready still wins over the watchdog in the same cycle.
          if (mem_ready) begin
            if (!we_q) resp_data_q <= mem_rdata;
            resp_valid_q <= NUM_REQ'(1) << owner_q;
            state_q      <= ARB_RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            timeout_id_q  <= 2'(owner_q);
            state_q       <= ARB_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign timeout_err = timeout_err_q;
  assign timeout_id  = timeout_id_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port Lisp heap memory (12-bit cell address, 16-bit tagged word) among NUM_REQ requesters: evaluator core, program loader, collector.
- Round-robin arbitration. One outstanding access at a time. Read/write pass-through with per-requester response pulse.
- Watchdog flags a memory that never returns mem_ready.
- Sits between requesters and the memory; sole driver of the memory request port.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = evaluator, 1 = loader, 2 = collector)
ADDR_W, 12, cell address width
DATA_W, 16, tagged word width
TIMEOUT, 64, max cycles in WAIT before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held until granted
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_grant  out  NUM_REQ  one-hot, one-cycle accept pulse
resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
resp_data  out  DATA_W  read data; valid with resp_valid, held until next response
mem_req  out  1  one-cycle request pulse to memory
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  ADDR_W  address, held from ISSUE until the next grant
mem_wdata  out  DATA_W  write data, held like mem_addr
mem_ready  in  1  memory completion pulse
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
timeout_err  out  1  sticky watchdog flag
timeout_id  out  2  requester index of the aborted access

Behaviour:
- Reset (also mid-transaction): state IDLE. All outputs 0, including resp_data, mem_addr, mem_wdata, timeout_err and timeout_id. Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority. Any in-flight access is abandoned; no resp_valid is issued for it.
- IDLE:
  - Winner w = first i with req_valid[i], scanning from (last+1) mod NUM_REQ upward with wrap.
  - req_grant[w] asserts combinationally in the same cycle.
  - On that edge: latch w, req_we[w], req_addr[w] and req_wdata[w] into owner/we/addr/wdata registers; last <= w; go to ISSUE.
  - No valid: stay in IDLE, no grant.
- Requester rules:
  - A requester may drop req_valid before grant; this is legal and produces no grant.
  - A requester still asserting req_valid in the cycle after its grant is making a new request.
- ISSUE: mem_req=1 for exactly one cycle with latched we/addr/wdata. Clear watchdog counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On mem_ready: resp_data <= mem_rdata for reads; for writes resp_data is unchanged. Go to RESP.
  - If counter reaches TIMEOUT-1 with no mem_ready: timeout_err <= 1, timeout_id <= owner, go to IDLE with no resp_valid.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- RESP: resp_valid[owner]=1 for one cycle. Go to IDLE.
- mem_ready outside WAIT is ignored (stale or spurious).
- Latency: grant at cycle 0, mem_req at 1, mem_ready earliest at 2, resp_valid at 3. Next grant is possible at cycle 4.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,0,… No requester waits more than NUM_REQ-1 transactions.
- Width rules:
  - Watchdog counter is $clog2(TIMEOUT+1) bits.
  - The round-robin index wraps modulo NUM_REQ; it must be correct for non-power-of-2 values.
- timeout_err clears only on rst.

Decomposition:
- lisp_defs package:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}.
  - Requester index constants REQ_EVAL=0, REQ_LOADER=1, REQ_GC=2.
  - MEM_TIMEOUT default.
- One sub-module, rr_select: combinational round-robin picker. Inputs: valid vector and last index. Outputs: winner index and any_valid.

Test Plan:
- Single read: req_valid[0], addr 0x010, memory returns 0x1234 two cycles after mem_req → grant[0] at cycle 0, mem_req with mem_addr=0x010 at cycle 1, resp_valid[0] with resp_data=0x1234 one cycle after mem_ready.
- Contention: all three valid continuously from reset → grant order 0,1,2,0,1,2. Each resp_valid reaches only the matching requester.
- Write pass-through: requester 1 writes 0xBEEF to 0x0FF → mem_we=1, mem_addr=0x0FF, mem_wdata=0xBEEF during the mem_req cycle. resp_valid[1] follows; resp_data is unchanged.
- Timeout: requester 2 reads and mem_ready is never asserted → after TIMEOUT cycles in WAIT, timeout_err=1 and timeout_id=2, no resp_valid, back in IDLE. The next request from requester 0 is granted normally.
- Reset mid-WAIT: assert rst during WAIT, then send mem_ready → all outputs 0, no resp_valid. The next grant goes to requester 0.
- Spurious mem_ready in IDLE with rdata 0xDEAD → resp_data stays 0 and no resp_valid.
